// File: rtl/id_ex_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard and stall controller.
package id_ex_hazard_ctrl_pkg;

    // RUN: normal issue; MD_BUSY: a mul/div is occupying EX
    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam int REG_W_DEF = 5;

    // Register 0 is hardwired to zero, so a load targeting it never creates a hazard
    localparam logic [REG_W_DEF-1:0] ZERO_REG = '0;

endpackage

// File: rtl/id_ex_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
module hazard_detect
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_to_reg,
    input  logic [REG_W-1:0] ex_rt,
    output logic             load_use
);

    logic ex_rt_live;

    // rt only matters when the ID instruction actually reads it
    always_comb begin
        ex_rt_live = (ex_rt != REG_W'(ZERO_REG));
        load_use   = ex_mem_to_reg & ex_rt_live &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
    end

endmodule

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard and stall controller: sequences PC, IF/ID, ID/EX and EX/MEM strobes.
// Priority each cycle: mem_stall > branch_taken > mul/div > load_use > normal.
// Optional stall_cycles counter enabled by defining HAZARD_STALL_COUNT_EN.
module id_ex_hazard_ctrl
    import id_ex_hazard_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 4,
    parameter int REG_W         = REG_W_DEF
`ifdef HAZARD_STALL_COUNT_EN
    ,
    parameter int CNT_W         = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_to_reg,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_muldiv,
    input  logic             branch_taken,
    input  logic             mem_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_bubble,
`ifdef HAZARD_STALL_COUNT_EN
    output logic [CNT_W-1:0] stall_cycles,
`endif
    output logic             busy
);

    // Counter only needs to hold MULDIV_CYCLES-2
    localparam int CW = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            md_done, md_done_nx;
    logic            load_use;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rt         (ex_rt),
        .load_use      (load_use)
    );

    // State register; reset aborts any mul/div in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            cnt     <= '0;
            md_done <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            md_done <= md_done_nx;
        end
    end

    // Next state and strobes; md_done marks the cycle the held mul/div is released
    always_comb begin
        state_nx      = state;
        cnt_nx        = cnt;
        md_done_nx    = md_done;
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_bubble  = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_bubble = 1'b0;
        if (!rst) begin
            state_nx   = RUN;
            cnt_nx     = '0;
            md_done_nx = 1'b0;
        end else if (mem_stall) begin
            id_ex_hold = 1'b1;
        end else if (branch_taken) begin
            pc_write      = 1'b1;
            if_id_flush   = 1'b1;
            id_ex_bubble  = 1'b1;
            ex_mem_bubble = 1'b1;
            state_nx      = RUN;
            md_done_nx    = 1'b0;
        end else if (state == MD_BUSY) begin
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            if (cnt == '0) begin
                state_nx   = RUN;
                md_done_nx = 1'b1;
            end else begin
                cnt_nx = cnt - CW'(1);
            end
        end else if (!md_done && ex_muldiv) begin
            id_ex_hold    = 1'b1;
            ex_mem_bubble = 1'b1;
            state_nx      = MD_BUSY;
            cnt_nx        = CW'(MULDIV_CYCLES - 2);
        end else begin
            md_done_nx = 1'b0;
            if (load_use) begin
                id_ex_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    assign busy = rst & (state == MD_BUSY);

`ifdef HAZARD_STALL_COUNT_EN
    // Count frozen-PC cycles, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Self-checking bench for id_ex_hazard_ctrl: vector table, directed sequences, random vs. model.
module tb_id_ex_hazard_ctrl;

    localparam int MD = 4;

    // Output packing: {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, busy}
    localparam logic [6:0] O_NORM = 7'b1100000;
    localparam logic [6:0] O_LU   = 7'b0001000;
    localparam logic [6:0] O_MDE  = 7'b0000110;
    localparam logic [6:0] O_MDB  = 7'b0000111;
    localparam logic [6:0] O_BR   = 7'b1011010;
    localparam logic [6:0] O_MS   = 7'b0000100;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_to_reg, ex_muldiv, branch_taken, mem_stall;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, busy;
`ifdef HAZARD_STALL_COUNT_EN
    logic [15:0] stall_cycles;
`endif
    int exp_stall = 0;

    int n_vec = 0;
    int n_bad = 0;

    logic [6:0] act;
    assign act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, id_ex_hold, ex_mem_bubble, busy};

    id_ex_hazard_ctrl #(.MULDIV_CYCLES(MD), .REG_W(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_rt         (ex_rt),
        .ex_muldiv     (ex_muldiv),
        .branch_taken  (branch_taken),
        .mem_stall     (mem_stall),
        .pc_write      (pc_write),
        .if_id_write   (if_id_write),
        .if_id_flush   (if_id_flush),
        .id_ex_bubble  (id_ex_bubble),
        .id_ex_hold    (id_ex_hold),
        .ex_mem_bubble (ex_mem_bubble),
`ifdef HAZARD_STALL_COUNT_EN
        .stall_cycles  (stall_cycles),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ur;
        logic       m2r;
        logic [4:0] ert;
        logic       md;
        logic       br;
        logic       ms;
        logic [6:0] exp;
        logic       bnext;
        string      name;
    } vec_t;

    vec_t vecs[12];

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                         input logic m2r, input logic [4:0] ert, input logic md,
                         input logic br, input logic ms);
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rt    = ur;
        ex_mem_to_reg = m2r;
        ex_rt         = ert;
        ex_muldiv     = md;
        branch_taken  = br;
        mem_stall     = ms;
    endtask

    task automatic chk(input logic [6:0] exp, input string name);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: outputs got %b want %b", name, act, exp);
        end
`ifdef HAZARD_STALL_COUNT_EN
        n_vec++;
        if (stall_cycles !== 16'(exp_stall)) begin
            n_bad++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, exp_stall);
        end
`endif
        if (rst && !exp[6]) exp_stall++;
    endtask

    // One pipeline cycle: inputs change just after the edge, outputs checked at the falling edge
    task automatic cyc(input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                       input logic m2r, input logic [4:0] ert, input logic md,
                       input logic br, input logic ms, input logic [6:0] exp, input string name);
        @(posedge clk);
        #1;
        drive(rs, rt, ur, m2r, ert, md, br, ms);
        @(negedge clk);
        chk(exp, name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         served;
        bit         released;
        logic [4:0] rs, rt, ert;
        logic       ur, m2r, md, br, ms, lu, bsy;
        logic [6:0] e;

        //            rs  rt  ur m2r ert md br ms  expected       bnext name
        vecs[0]  = '{5,  0, 0, 1, 5,  0, 0, 0, O_LU,           0, "lu_rs"};
        vecs[1]  = '{0,  0, 1, 1, 0,  0, 0, 0, O_NORM,         0, "lu_r0"};
        vecs[2]  = '{3,  7, 1, 1, 7,  0, 0, 0, O_LU,           0, "lu_rt_used"};
        vecs[3]  = '{3,  7, 0, 1, 7,  0, 0, 0, O_NORM,         0, "lu_rt_unused"};
        vecs[4]  = '{5,  5, 1, 0, 5,  0, 0, 0, O_NORM,         0, "no_load"};
        vecs[5]  = '{1,  2, 1, 0, 3,  1, 0, 0, O_MDE,          1, "md_entry"};
        vecs[6]  = '{5,  0, 0, 1, 5,  1, 0, 0, O_MDE,          1, "md_over_lu"};
        vecs[7]  = '{5,  0, 0, 1, 5,  0, 1, 0, O_BR,           0, "br_over_lu"};
        vecs[8]  = '{0,  0, 0, 0, 0,  0, 1, 1, O_MS,           0, "ms_over_br"};
        vecs[9]  = '{0,  0, 0, 0, 0,  1, 0, 1, O_MS,           0, "ms_over_md"};
        vecs[10] = '{4,  6, 1, 1, 9,  0, 0, 0, O_NORM,         0, "lu_miss"};
        vecs[11] = '{0,  0, 0, 0, 0,  0, 1, 0, O_BR,           0, "br_alone"};

        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk(7'b0, "reset_state");
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].m2r, vecs[i].ert,
                vecs[i].md, vecs[i].br, vecs[i].ms, vecs[i].exp, vecs[i].name);
            cyc(0, 0, 0, 0, 0, 0, 1, 0, O_BR | {6'b0, vecs[i].bnext}, "recover_br");
        end

        // Load-use stalls exactly one cycle
        cyc(5, 0, 0, 1, 5, 0, 0, 0, O_LU,   "seq_lu_stall");
        cyc(5, 0, 0, 0, 0, 0, 0, 0, O_NORM, "seq_lu_after");

        // Full mul/div, release with ex_muldiv still high, then back-to-back entry
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDE,  "seq_md_entry");
        for (int k = 0; k < MD - 1; k++) cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDB, "seq_md_busy");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_NORM, "seq_md_release");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDE,  "seq_md_b2b");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, O_BR | 7'b1, "seq_md_b2b_br");

        // Branch on the second busy cycle aborts the mul/div
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDE,  "seq_brmd_entry");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDB,  "seq_brmd_busy1");
        cyc(0, 0, 0, 0, 0, 1, 1, 0, O_BR | 7'b1, "seq_brmd_branch");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, O_NORM, "seq_brmd_after");

        // Memory freeze with cnt = 1 leaves two busy cycles afterwards
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDE,  "seq_ms_entry");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDB,  "seq_ms_busy1");
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0, 1, 0, 1, O_MS | 7'b1, "seq_ms_freeze");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDB,  "seq_ms_busy2");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDB,  "seq_ms_busy3");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_NORM, "seq_ms_release");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, O_NORM, "seq_ms_after");

        // Asynchronous reset between edges mid-busy
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDE,  "seq_rst_entry");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, O_MDB,  "seq_rst_busy");
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_stall = 0;
        #1;
        chk(7'b0, "async_reset");
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 0, 0, O_NORM, "post_reset");

        // Random traffic against a cycle-count reference model
        cyc(0, 0, 0, 0, 0, 0, 1, 0, O_BR, "rand_sync");
        served   = 0;
        released = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            ert = 5'($urandom_range(0, 3));
            ur  = 1'($urandom_range(0, 1));
            m2r = 1'($urandom_range(0, 1));
            md  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            ms  = ($urandom_range(0, 7) == 0);
            lu  = m2r && (ert != 0) && ((ert == rs) || (ur && (ert == rt)));
            bsy = (served > 0);
            if (ms) begin
                e = O_MS | {6'b0, bsy};
            end else if (br) begin
                e        = O_BR | {6'b0, bsy};
                served   = 0;
                released = 1'b0;
            end else if (served > 0) begin
                e = O_MDB;
                served++;
                if (served == MD) begin
                    served   = 0;
                    released = 1'b1;
                end
            end else if (!released && md) begin
                e      = O_MDE;
                served = 1;
            end else begin
                released = 1'b0;
                e        = lu ? O_LU : O_NORM;
            end
            cyc(rs, rt, ur, m2r, ert, md, br, ms, e, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- Hazard and stall controller that sequences the ID/EX pipeline latch and its neighbours.
- Decides each cycle whether PC and IF/ID advance, whether ID/EX loads, holds or takes a bubble, and whether EX/MEM takes a bubble.
- Handles four cases: load-use hazards, multi-cycle mul/div occupancy of EX, taken-branch flush, and data-memory freeze.
- Sits beside the decode stage; drives write-enable, flush and hold strobes into the IF/ID, ID/EX and EX/MEM latches.

Parameters:
- MULDIV_CYCLES, 4, total cycles a mul/div instruction occupies EX (legal range >= 2).
- REG_W, 5, register-specifier width.
- CNT_W, 16, stall-counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs  in  REG_W  rs of the instruction in ID.
- id_rt  in  REG_W  rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- ex_mem_to_reg  in  1  instruction in EX is a load (ID/EX mem_to_reg_reg).
- ex_rt  in  REG_W  load destination (ID/EX rt_reg).
- ex_muldiv  in  1  instruction in EX is mul/div.
- branch_taken  in  1  branch resolved taken in MEM.
- mem_stall  in  1  data memory not ready.
- pc_write  out  1  PC may update.
- if_id_write  out  1  IF/ID may load.
- if_id_flush  out  1  IF/ID clears to NOP.
- id_ex_bubble  out  1  ID/EX loads zeroed controls.
- id_ex_hold  out  1  ID/EX keeps its contents.
- ex_mem_bubble  out  1  EX/MEM loads zeroed controls.
- busy  out  1  FSM in MD_BUSY.

Behaviour:
- All outputs are combinational from the registered state plus the current inputs. Hazard response has zero-cycle latency.
- While rst = 0:
  - State is RUN; cnt = 0; md_done = 0.
  - All outputs are 0, including pc_write and if_id_write.
  - Reset mid-mul/div aborts it.
- load_use = ex_mem_to_reg & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- Priority per cycle, highest first: mem_stall > branch_taken > mul/div > load_use > normal.
- mem_stall = 1:
  - Outputs: pc_write = 0, if_id_write = 0, id_ex_hold = 1; all flush and bubble outputs are 0.
  - State, cnt and md_done are frozen.
- branch_taken = 1 (and mem_stall = 0):
  - Outputs: pc_write = 1, if_id_flush = 1, id_ex_bubble = 1, ex_mem_bubble = 1.
  - Next state: RUN, md_done = 0.
  - Aborts any mul/div, including in MD_BUSY.
- RUN, ex_muldiv = 1, md_done = 0 (mul/div entry cycle):
  - Outputs: pc_write = 0, if_id_write = 0, id_ex_hold = 1, ex_mem_bubble = 1.
  - Next state: MD_BUSY with cnt = MULDIV_CYCLES-2.
- MD_BUSY:
  - Outputs: same stall outputs as the entry cycle; busy = 1.
  - If cnt == 0: next state RUN, md_done = 1. Else cnt decrements.
- RUN with md_done = 1:
  - The held mul/div advances normally; md_done clears at this clock edge.
  - ex_muldiv is ignored in this cycle.
- Total stall cycles for a mul/div = MULDIV_CYCLES. It then advances on the following cycle.
- load_use in RUN (no higher-priority event):
  - Outputs: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
  - Lasts exactly 1 cycle, since the bubble removes the load from EX.
- Normal: pc_write = 1, if_id_write = 1; every other output 0.
- Back-to-back mul/div: the next one enters MD_BUSY on the cycle after the first advances.

Optional Feature:
- Macro HAZARD_STALL_COUNT_EN.
- When defined:
  - Adds output stall_cycles, width CNT_W.
  - Increments on every cycle where rst = 1 and pc_write = 0.
  - Saturates at all-ones; reset value 0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - State enum: RUN = 0, MD_BUSY = 1.
  - REG_W default and the zero-register constant.
- Sub-module hazard_detect: purely combinational load_use compare. The FSM, counter and priority mux stay in the top module.

Test Plan:
1. Load-use: ex_mem_to_reg = 1, ex_rt = 5, id_rs = 5 -> one cycle of pc_write = 0, if_id_write = 0, id_ex_bubble = 1; then normal. With ex_rt = 0 -> no stall.
2. rt hazard gating: ex_rt = 7, id_rt = 7 -> stall only when id_uses_rt = 1.
3. Mul/div: ex_muldiv = 1 with MULDIV_CYCLES = 4 -> 4 cycles of id_ex_hold = 1 and ex_mem_bubble = 1; busy high for 3 of them; 5th cycle normal with ex_muldiv still 1.
4. Branch during MD_BUSY: branch_taken pulses on 2nd busy cycle -> if_id_flush = 1, id_ex_bubble = 1, pc_write = 1 that cycle; next cycle RUN, busy = 0.
5. Freeze: mem_stall = 1 for 3 cycles mid-MD_BUSY (cnt = 1) -> cnt unchanged, all frozen; resumes with 2 remaining busy cycles.
6. Async reset: drop rst mid-MD_BUSY between clock edges -> outputs 0 immediately; after release, state RUN and busy = 0. With HAZARD_STALL_COUNT_EN defined, stall_cycles = 0.
